// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and the
// default filler instruction word.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_WORD_DEF = 16'hFFFF;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: instruction, its pc and a valid flag.
// Ports: load_i capture, flush_i clear to NOP, kill_i drop valid, else hold.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 16,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              kill_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  localparam logic [INST_W-1:0] NOP = INST_W'(NOP_WORD);

  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      // Filler words are captured but never presented as real work.
      valid_q <= (inst_i != NOP);
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory word address, captures the
// returned word into IF/ID, handles stall, branch flush and end-of-program halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 16,
  parameter int          PC_LAST  = 255,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [INST_W-1:0] i_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_if_inst,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic              o_if_valid,
  output logic              o_halted
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PC_LAST);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              halted_q;

  logic              run;
  logic              flush;
  logic              load;
  logic              kill;

  // Branch beats stall; nothing reaches IF/ID outside RUN.
  assign run   = (state_q == ST_RUN);
  assign flush = run & i_branch_taken;
  assign load  = run & ~i_branch_taken & ~i_stall;
  assign kill  = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: state_q <= ST_RUN;
        ST_RUN: begin
          if (i_branch_taken) begin
            pc_q <= i_branch_target;
          end else if (!i_stall) begin
            if (pc_q >= LAST) begin
              state_q  <= ST_DONE;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .flush_i(flush),
    .kill_i (kill),
    .inst_i (i_inst),
    .pc_i   (pc_q),
    .inst_o (o_if_inst),
    .pc_o   (o_if_pc),
    .valid_o(o_if_valid)
  );

  assign o_pc     = pc_q;
  assign o_halted = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a negedge-read 256x16 memory model.
// Each step samples 1ns after the posedge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic [15:0] i_inst;
  logic [31:0] o_pc;
  logic [15:0] o_if_inst;
  logic [31:0] o_if_pc;
  logic        o_if_valid;
  logic        o_halted;

  logic [15:0] mem [256];
  int          n_vec;
  int          n_err;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_target(i_branch_target),
    .i_inst         (i_inst),
    .o_pc           (o_pc),
    .o_if_inst      (o_if_inst),
    .o_if_pc        (o_if_pc),
    .o_if_valid     (o_if_valid),
    .o_halted       (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) i_inst <= mem[o_pc[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, o_pc, 32'd0);
    chk({tag, ".inst"}, 32'(o_if_inst), 32'hFFFF);
    chk({tag, ".ifpc"}, o_if_pc, 32'd0);
    chk({tag, ".valid"}, 32'(o_if_valid), 32'd0);
    chk({tag, ".halt"}, 32'(o_halted), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = {8'h10, 8'(i)};
    mem[0] = 16'hB300;
    mem[1] = 16'hB200;
    mem[2] = 16'hB100;
    mem[3] = 16'h8B11;
    for (int i = 4; i <= 8; i++) mem[i] = 16'hFFFF;
    mem[9] = 16'hE00F;
    i_inst          = 16'hFFFF;
    rst             = 1'b1;
    i_stall         = 1'b0;
    i_branch_taken  = 1'b0;
    i_branch_target = '0;

    // reset values, then INIT cycle and first captures
    #12;
    chk_reset("rst0");
    rst = 1'b0;
    step();
    chk("init.pc", o_pc, 32'd0);
    chk("init.valid", 32'(o_if_valid), 32'd0);
    step();
    chk("c0.pc", o_pc, 32'd1);
    chk("c0.inst", 32'(o_if_inst), 32'hB300);
    chk("c0.ifpc", o_if_pc, 32'd0);
    chk("c0.valid", 32'(o_if_valid), 32'd1);
    step();
    chk("c1.pc", o_pc, 32'd2);
    chk("c1.inst", 32'(o_if_inst), 32'hB200);

    // stall three cycles at pc 2
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stl.pc", o_pc, 32'd2);
      chk("stl.inst", 32'(o_if_inst), 32'hB200);
      chk("stl.ifpc", o_if_pc, 32'd1);
      chk("stl.valid", 32'(o_if_valid), 32'd1);
    end
    i_stall = 1'b0;
    step();
    chk("res.pc", o_pc, 32'd3);
    chk("res.inst", 32'(o_if_inst), 32'hB100);
    chk("res.ifpc", o_if_pc, 32'd2);

    // branch wins over stall
    i_branch_taken  = 1'b1;
    i_branch_target = 32'd9;
    i_stall         = 1'b1;
    step();
    chk("br.pc", o_pc, 32'd9);
    chk("br.valid", 32'(o_if_valid), 32'd0);
    chk("br.inst", 32'(o_if_inst), 32'hFFFF);
    i_branch_taken = 1'b0;
    i_stall        = 1'b0;
    step();
    chk("br9.inst", 32'(o_if_inst), 32'hE00F);
    chk("br9.ifpc", o_if_pc, 32'd9);
    chk("br9.valid", 32'(o_if_valid), 32'd1);
    chk("br9.pc", o_pc, 32'd10);

    // NOP filler at 4..8
    i_branch_taken  = 1'b1;
    i_branch_target = 32'd4;
    step();
    chk("nb.pc", o_pc, 32'd4);
    i_branch_taken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("nop.ifpc", o_if_pc, 32'(4 + k));
      chk("nop.inst", 32'(o_if_inst), 32'hFFFF);
      chk("nop.valid", 32'(o_if_valid), 32'd0);
      chk("nop.pc", o_pc, 32'(5 + k));
    end
    step();
    chk("nop9.valid", 32'(o_if_valid), 32'd1);
    chk("nop9.ifpc", o_if_pc, 32'd9);

    // wrong-path fetch of the last address must not halt
    i_branch_taken  = 1'b1;
    i_branch_target = 32'd255;
    step();
    chk("wp.pc", o_pc, 32'd255);
    i_branch_target = 32'd250;
    step();
    chk("wp2.pc", o_pc, 32'd250);
    chk("wp2.halt", 32'(o_halted), 32'd0);
    i_branch_taken = 1'b0;

    // run to the end of program
    for (int k = 0; k < 5; k++) begin
      step();
      chk("end.ifpc", o_if_pc, 32'(250 + k));
      chk("end.pc", o_pc, 32'(251 + k));
    end
    step();
    chk("last.ifpc", o_if_pc, 32'd255);
    chk("last.inst", 32'(o_if_inst), 32'h10FF);
    chk("last.valid", 32'(o_if_valid), 32'd1);
    chk("last.halt", 32'(o_halted), 32'd1);
    chk("last.pc", o_pc, 32'd255);
    i_branch_taken  = 1'b1;
    i_branch_target = 32'd3;
    step();
    chk("dn.pc", o_pc, 32'd255);
    chk("dn.valid", 32'(o_if_valid), 32'd0);
    chk("dn.inst", 32'(o_if_inst), 32'h10FF);
    chk("dn.halt", 32'(o_halted), 32'd1);
    i_branch_taken = 1'b0;
    step();
    chk("dn2.pc", o_pc, 32'd255);

    // async reset from DONE, between edges
    #2 rst = 1'b1;
    #1 chk_reset("rst1");
    #1 rst = 1'b0;
    step();
    chk("ri.pc", o_pc, 32'd0);
    chk("ri.valid", 32'(o_if_valid), 32'd0);
    step();
    chk("rc.inst", 32'(o_if_inst), 32'hB300);
    chk("rc.pc", o_pc, 32'd1);

    // async reset mid-run with a branch pending; INIT ignores it
    i_branch_taken  = 1'b1;
    i_branch_target = 32'd77;
    #2 rst = 1'b1;
    #1 chk_reset("rst2");
    #1 rst = 1'b0;
    step();
    chk("ri2.pc", o_pc, 32'd0);
    chk("ri2.valid", 32'(o_if_valid), 32'd0);

    // target beyond the last address halts after one capture
    i_branch_target = 32'd300;
    step();
    chk("far.pc", o_pc, 32'd300);
    chk("far.valid", 32'(o_if_valid), 32'd0);
    i_branch_taken = 1'b0;
    step();
    chk("far.ifpc", o_if_pc, 32'd300);
    chk("far.inst", 32'(o_if_inst), 32'h102C);
    chk("far.halt", 32'(o_halted), 32'd1);
    chk("far.pc2", o_pc, 32'd300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
